// File: rtl/wb_commit_unit.sv
// wb_commit_unit -- registered writeback/commit stage for the RV32I core.
//
// Chooses the rd source (pc_next, immediate, alu_res or load data). It extracts
// load data by byte, half or word and applies sign or zero extension. When load
// data is late, it holds the load in WAIT_MEM until mem_rvalid arrives. It drives
// one registered register-file write port.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   valid/ready handshake with the MEM stage
//   in_rd_sel             rd source: 00 pc_next, 01 immediate, 10 alu_res, 11 load
//   in_rd_we, in_rd_addr  rd write enable and destination register
//   in_funct3, in_addr_lo load type and low bits of the load address
//   pc_next, immediate, alu_res  non-load rd sources
//   mem_rvalid, mem_rdata load data return (aligned memory word)
//   flush                 discards the accepting or pending instruction
//   rf_we, rf_waddr, rf_wdata  registered register-file write port
//   busy                  high while waiting for load data
//
// Optional: define WB_MISALIGN_CHECK_EN to add the load_misalign output. A
// misaligned LH/LHU/LW/LD then pulses load_misalign and skips the write.
// Without it, misaligned offsets are truncated to the natural lane.
module wb_commit_unit #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OFS_W  = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_rd_sel,
  input  logic              in_rd_we,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [2:0]        in_funct3,
  input  logic [OFS_W-1:0]  in_addr_lo,
  input  logic [XLEN-1:0]   pc_next,
  input  logic [XLEN-1:0]   immediate,
  input  logic [XLEN-1:0]   alu_res,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
`ifdef WB_MISALIGN_CHECK_EN
  output logic              load_misalign,
`endif
  output logic              busy
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t              state, next_state;
  logic [REG_AW-1:0]   cap_addr;
  logic                cap_we;
  logic [2:0]          cap_f3;
  logic [OFS_W-1:0]    cap_lo;

  logic                commit, cap_en, c_load, c_mis, c_we;
  logic [REG_AW-1:0]   c_addr;
  logic [2:0]          c_f3;
  logic [OFS_W-1:0]    c_lo;
  logic [XLEN-1:0]     c_data;

  function automatic logic [XLEN-1:0] extract(input logic [2:0] f3,
                                              input logic [OFS_W-1:0] lo,
                                              input logic [XLEN-1:0] d);
    logic [XLEN-1:0] b_sh, h_sh, w_sh, r;
    b_sh = d >> {lo, 3'b000};
    h_sh = d >> {lo[OFS_W-1:1], 4'b0000};
    if (XLEN == 64) w_sh = d >> {lo[OFS_W-1], 5'b00000};
    else            w_sh = d;
    r = '0;
    case (f3)
      3'b000: r = XLEN'($signed(b_sh[7:0]));
      3'b001: r = XLEN'($signed(h_sh[15:0]));
      3'b010: r = XLEN'($signed(w_sh[31:0]));
      3'b100: r = XLEN'(b_sh[7:0]);
      3'b101: r = XLEN'(h_sh[15:0]);
      3'b011: if (XLEN == 64) r = d;
      3'b110: if (XLEN == 64) r = XLEN'(w_sh[31:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [OFS_W-1:0] lo);
    logic m;
    m = 1'b0;
    case (f3)
      3'b001, 3'b101: m = lo[0];
      3'b010:         m = (lo[1:0] != 2'b00);
      3'b011:         if (XLEN == 64) m = (lo != '0);
      default:        m = 1'b0;
    endcase
    return m;
  endfunction

  assign in_ready = (state == IDLE);
  assign busy     = (state == WAIT_MEM);

  // A commit can come from the live MEM inputs (IDLE) or from the captured load
  // fields (WAIT_MEM). Both paths feed one shared write mux.
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    cap_en     = 1'b0;
    c_load     = 1'b0;
    c_addr     = in_rd_addr;
    c_we       = in_rd_we;
    c_f3       = in_funct3;
    c_lo       = in_addr_lo;
    case (state)
      IDLE: begin
        if (in_valid && !flush) begin
          if (in_rd_sel != 2'b11) begin
            commit = 1'b1;
          end else if (mem_rvalid) begin
            commit = 1'b1;
            c_load = 1'b1;
          end else begin
            cap_en     = 1'b1;
            next_state = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        c_addr = cap_addr;
        c_we   = cap_we;
        c_f3   = cap_f3;
        c_lo   = cap_lo;
        if (flush) begin
          next_state = IDLE;
        end else if (mem_rvalid) begin
          commit     = 1'b1;
          c_load     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase

    case (in_rd_sel)
      2'b00:   c_data = pc_next;
      2'b01:   c_data = immediate;
      default: c_data = alu_res;
    endcase
    if (c_load) c_data = extract(c_f3, c_lo, mem_rdata);

`ifdef WB_MISALIGN_CHECK_EN
    c_mis = c_load && misaligned(c_f3, c_lo);
`else
    c_mis = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap_addr <= '0;
      cap_we   <= 1'b0;
      cap_f3   <= '0;
      cap_lo   <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state <= next_state;
      if (cap_en) begin
        cap_addr <= in_rd_addr;
        cap_we   <= in_rd_we;
        cap_f3   <= in_funct3;
        cap_lo   <= in_addr_lo;
      end
      // x0 writes still update address/data but never strobe
      rf_we <= commit && !c_mis && c_we && (c_addr != '0);
      if (commit && !c_mis) begin
        rf_waddr <= c_addr;
        rf_wdata <= c_data;
      end
    end
  end

`ifdef WB_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) load_misalign <= 1'b0;
    else        load_misalign <= commit && c_mis;
  end
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
module tb_wb_commit_unit;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_rd_sel;
  logic        in_rd_we;
  logic [4:0]  in_rd_addr;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] pc_next, immediate, alu_res, mem_rdata;
  logic        mem_rvalid, flush;
  logic        rf_we, busy;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_MISALIGN_CHECK_EN
  logic        load_misalign;
`endif

  int total = 0;
  int bad   = 0;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;

  wb_commit_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_sel(in_rd_sel), .in_rd_we(in_rd_we), .in_rd_addr(in_rd_addr),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .pc_next(pc_next),
    .immediate(immediate), .alu_res(alu_res), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
`ifdef WB_MISALIGN_CHECK_EN
    .load_misalign(load_misalign),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference load result from the architectural rules, using plain arithmetic
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lo, input logic [31:0] d);
    longint v;
    case (f3)
      3'd0: begin v = (d / (1 << (8*lo))) % 256;        if (v >= 128)   v = v - 256;   end
      3'd1: begin v = (d / (1 << (16*(lo/2)))) % 65536; if (v >= 32768) v = v - 65536; end
      3'd2: v = d;
      3'd4: v = (d / (1 << (8*lo))) % 256;
      3'd5: v = (d / (1 << (16*(lo/2)))) % 65536;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic we, input logic [4:0] ra,
                       input logic [2:0] f3, input logic [1:0] lo, input logic rv,
                       input logic [31:0] rd);
    in_valid = 1'b1; in_rd_sel = sel; in_rd_we = we; in_rd_addr = ra;
    in_funct3 = f3; in_addr_lo = lo; mem_rvalid = rv; mem_rdata = rd;
  endtask

  task automatic idle;
    in_valid = 1'b0; mem_rvalid = 1'b0; flush = 1'b0;
    in_rd_addr = 5'($urandom); in_funct3 = 3'($urandom); in_addr_lo = 2'($urandom);
    in_rd_we = 1'($urandom); in_rd_sel = 2'($urandom);
  endtask

  task automatic do_reset;
    rst_n = 1'b0; #2;
    total++; if (rf_we !== 1'b0)   begin bad++; $display("FAIL rst_we got=%0h exp=0", rf_we); end
    total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL rst_waddr got=%0h exp=0", rf_waddr); end
    total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL rst_wdata got=%0h exp=0", rf_wdata); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    @(negedge clk); rst_n = 1'b1; exp_addr = '0; exp_data = '0;
    step;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0h exp=1", in_ready); end
  endtask

  task automatic test_reset;
    idle; pc_next = '0; immediate = '0; alu_res = '0; mem_rdata = '0;
    do_reset;
  endtask

  task automatic test_alu;
    alu_res = 32'h1234_5678;
    drive(2'b10, 1'b1, 5'd5, 3'd0, 2'd0, 1'b0, 32'h0);
    step; idle; alu_res = 32'hDEAD_0000;
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL alu_we got=%0h exp=1", rf_we); end
    total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL alu_waddr got=%0h exp=5", rf_waddr); end
    total++; if (rf_wdata !== 32'h1234_5678) begin bad++; $display("FAIL alu_wdata got=%0h exp=12345678", rf_wdata); end
    step;
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL alu_pulse got=%0h exp=0", rf_we); end
    total++; if (rf_wdata !== 32'h1234_5678) begin bad++; $display("FAIL alu_hold got=%0h exp=12345678", rf_wdata); end
    exp_addr = 5'd5; exp_data = 32'h1234_5678;
  endtask

  task automatic test_load_now;
    drive(2'b11, 1'b1, 5'd7, 3'b000, 2'd3, 1'b1, 32'h80AA_BBCC);
    step; idle;
    total++; if (rf_wdata !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_wdata got=%0h exp=ffffff80", rf_wdata); end
    total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL lb_we got=%0h exp=1", rf_we); end
    drive(2'b11, 1'b1, 5'd7, 3'b100, 2'd3, 1'b1, 32'h80AA_BBCC);
    step; idle;
    total++; if (rf_wdata !== 32'h0000_0080) begin bad++; $display("FAIL lbu_wdata got=%0h exp=80", rf_wdata); end
    exp_addr = 5'd7; exp_data = 32'h80;
  endtask

  task automatic test_load_wait;
    drive(2'b11, 1'b1, 5'd9, 3'b101, 2'd2, 1'b0, 32'h0);
    step; idle;
    for (int k = 1; k <= 3; k++) begin
      total++; if (in_ready !== 1'b0 || busy !== 1'b1 || rf_we !== 1'b0)
        begin bad++; $display("FAIL wait_c%0d ready=%0h busy=%0h we=%0h exp 0/1/0", k, in_ready, busy, rf_we); end
      mem_rvalid = (k == 3); mem_rdata = (k == 3) ? 32'hBEEF_0001 : 32'h5555_5555;
      step;
    end
    mem_rvalid = 1'b0;
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h0000_BEEF)
      begin bad++; $display("FAIL lhu_wait we=%0h waddr=%0h wdata=%0h exp 1/9/beef", rf_we, rf_waddr, rf_wdata); end
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL lhu_idle busy=%0h ready=%0h exp 0/1", busy, in_ready); end
    exp_addr = 5'd9; exp_data = 32'hBEEF;
  endtask

  task automatic test_x0;
    pc_next = 32'h104;
    drive(2'b00, 1'b1, 5'd0, 3'd0, 2'd0, 1'b0, 32'h0);
    step; idle;
    total++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h104)
      begin bad++; $display("FAIL jal_x0 we=%0h waddr=%0h wdata=%0h exp 0/0/104", rf_we, rf_waddr, rf_wdata); end
    immediate = 32'hABCD_E000;
    drive(2'b01, 1'b1, 5'd1, 3'd0, 2'd0, 1'b0, 32'h0);
    step; idle;
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'hABCD_E000)
      begin bad++; $display("FAIL lui we=%0h waddr=%0h wdata=%0h exp 1/1/abcde000", rf_we, rf_waddr, rf_wdata); end
    exp_addr = 5'd1; exp_data = 32'hABCD_E000;
  endtask

  task automatic test_flush;
    // flush together with mem_rvalid while waiting
    drive(2'b11, 1'b1, 5'd3, 3'b010, 2'd0, 1'b0, 32'h0);
    step; idle;
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    step; idle;
    total++; if (rf_we !== 1'b0 || rf_wdata !== exp_data) begin bad++; $display("FAIL flush_wait we=%0h wdata=%0h exp 0/%0h", rf_we, rf_wdata, exp_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0h exp=1", in_ready); end
    // flush in the accept cycle
    alu_res = 32'h7777_7777;
    drive(2'b10, 1'b1, 5'd4, 3'd0, 2'd0, 1'b0, 32'h0); flush = 1'b1;
    step; idle;
    total++; if (rf_we !== 1'b0 || rf_waddr !== exp_addr) begin bad++; $display("FAIL flush_accept we=%0h waddr=%0h exp 0/%0h", rf_we, rf_waddr, exp_addr); end
    // reset while waiting
    drive(2'b11, 1'b1, 5'd6, 3'b010, 2'd0, 1'b0, 32'h0);
    step; idle; step;
    do_reset;
    mem_rvalid = 1'b1; mem_rdata = 32'h9999_9999;
    step; mem_rvalid = 1'b0;
    total++; if (rf_we !== 1'b0 || rf_wdata !== 32'd0 || busy !== 1'b0)
      begin bad++; $display("FAIL rst_wait we=%0h wdata=%0h busy=%0h exp 0/0/0", rf_we, rf_wdata, busy); end
  endtask

  task automatic test_misalign;
    drive(2'b11, 1'b1, 5'd8, 3'b010, 2'd2, 1'b1, 32'hCAFE_F00D);
    step; idle;
`ifdef WB_MISALIGN_CHECK_EN
    total++; if (load_misalign !== 1'b1 || rf_we !== 1'b0) begin bad++; $display("FAIL misalign mis=%0h we=%0h exp 1/0", load_misalign, rf_we); end
    step;
    total++; if (load_misalign !== 1'b0) begin bad++; $display("FAIL misalign_pulse got=%0h exp=0", load_misalign); end
`else
    total++; if (rf_we !== 1'b1 || rf_wdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL lw_trunc we=%0h wdata=%0h exp 1/cafef00d", rf_we, rf_wdata); end
    exp_addr = 5'd8; exp_data = 32'hCAFE_F00D;
`endif
  endtask

  task automatic test_random;
    logic [1:0] sel; logic [2:0] f3; logic [1:0] lo; logic [4:0] ra; logic we, fl, mis, wr;
    logic [31:0] dat, v; int dly;
    for (int n = 0; n < 300; n++) begin
      sel = 2'($urandom); f3 = 3'($urandom); lo = 2'($urandom); we = 1'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      dat = $urandom; pc_next = $urandom; immediate = $urandom; alu_res = $urandom;
      dly = (sel == 2'b11) ? $urandom_range(0, 3) : 0;
      fl = ($urandom_range(0, 9) == 0);
      case (sel)
        2'd0: v = pc_next;
        2'd1: v = immediate;
        2'd2: v = alu_res;
        default: v = ref_load(f3, int'(lo), dat);
      endcase
      mis = 1'b0;
`ifdef WB_MISALIGN_CHECK_EN
      mis = (sel == 2'b11) && ((((f3 == 3'd1) || (f3 == 3'd5)) && lo[0]) || ((f3 == 3'd2) && (lo != 2'd0)));
`endif
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rnd_ready n=%0d got=%0h exp=1", n, in_ready); end
      drive(sel, we, ra, f3, lo, (dly == 0), (dly == 0) ? dat : $urandom);
      flush = fl;
      step; idle; pc_next = $urandom; immediate = $urandom; alu_res = $urandom;
      if (!fl) begin
        for (int k = 1; k <= dly; k++) begin
          total++; if (busy !== 1'b1 || in_ready !== 1'b0 || rf_we !== 1'b0)
            begin bad++; $display("FAIL rnd_wait n=%0d busy=%0h ready=%0h we=%0h exp 1/0/0", n, busy, in_ready, rf_we); end
          mem_rvalid = (k == dly); mem_rdata = (k == dly) ? dat : $urandom;
          step; mem_rvalid = 1'b0;
        end
      end
      wr = !fl && !mis;
      if (wr) begin exp_addr = ra; exp_data = v; end
      total++; if (rf_we !== (wr && we && (ra != 5'd0)) || rf_waddr !== exp_addr || rf_wdata !== exp_data || busy !== 1'b0)
        begin bad++; $display("FAIL rnd_commit n=%0d sel=%0d f3=%0d lo=%0d we=%0h waddr=%0h wdata=%0h busy=%0h exp we=%0h waddr=%0h wdata=%0h",
          n, sel, f3, lo, rf_we, rf_waddr, rf_wdata, busy, (wr && we && (ra != 5'd0)), exp_addr, exp_data); end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_load_now;
    test_load_wait;
    test_x0;
    test_flush;
    test_misalign;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
